// File: rtl/cpu_test_sequencer_pkg.sv
// Shared definitions for the cpu test sequencer.
//   seq_state_e    : run-controller state encoding
//   DEF_MON_REG    : default register watched for the end-of-test signature
//   DEF_PASS_VALUE : default signature value meaning pass
//   cnt_width()    : bits needed to hold 0..max_val (at least 1)
package cpu_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_MON_REG    = 31;
  localparam int unsigned DEF_PASS_VALUE = 1;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_test_sequencer_if.sv
// Bus bundle between the host/bench and the cpu test sequencer.
//   start/load_*  : program stream and run request from the host
//   imem_*        : instruction memory write port driven by the sequencer
//   cpu_reset     : reset to the cpu core
//   mon_*         : snooped scalar register-file write port of the core
//   done/pass/timeout/result/cycle_count : test verdict
// Modports: master = host side, slave = sequencer side.
interface cpu_test_sequencer_if #(
  parameter int IADDR_W = 8,
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 8
);
  logic               start;
  logic               load_valid;
  logic               load_last;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               imem_we;
  logic [IADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_reset;
  logic               mon_we;
  logic [REG_AW-1:0]  mon_addr;
  logic [DATA_W-1:0]  mon_data;
  logic               done;
  logic               pass;
  logic               timeout;
  logic [DATA_W-1:0]  result;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    output start, load_valid, load_last, load_data, mon_we, mon_addr, mon_data,
    input  load_ready, imem_we, imem_addr, imem_wdata, cpu_reset,
           done, pass, timeout, result, cycle_count
  );

  modport slave (
    input  start, load_valid, load_last, load_data, mon_we, mon_addr, mon_data,
    output load_ready, imem_we, imem_addr, imem_wdata, cpu_reset,
           done, pass, timeout, result, cycle_count
  );
endinterface

// File: rtl/cpu_test_sequencer.sv
// Run controller between a host and a cpu core: streams a program into
// instruction memory with the core held in reset, releases reset after a
// programmable hold, then watches register-file writes for an end-of-test
// signature and reports pass/fail/timeout with the number of run cycles.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : cpu_test_sequencer_if.slave (load stream, imem write port,
//           cpu_reset, snooped regfile writes, verdict outputs)
module cpu_test_sequencer
  import cpu_test_sequencer_pkg::*;
#(
  parameter int IADDR_W      = 8,
  parameter int INSTR_W      = 32,
  parameter int PROG_WORDS   = 256,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 200,
  parameter int REG_AW       = 5,
  parameter int DATA_W       = 32,
  parameter int MON_REG      = DEF_MON_REG,
  parameter int PASS_VALUE   = DEF_PASS_VALUE
) (
  input logic                 clk,
  input logic                 reset,
  cpu_test_sequencer_if.slave bus
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam int WC_W  = cnt_width(PROG_WORDS);
  localparam int HC_W  = cnt_width(RESET_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  seq_state_e          state_q, state_d;
  logic [WC_W-1:0]     word_cnt_q;
  logic [HC_W-1:0]     hold_cnt_q;
  logic [CNT_W-1:0]    cycle_cnt_q;
  logic                imem_we_p1;
  logic [IADDR_W-1:0]  imem_addr_p1;
  logic [INSTR_W-1:0]  imem_wdata_p1;
  logic                pass_q;
  logic                timeout_q;
  logic [DATA_W-1:0]   result_q;
  logic                load_ready;
  logic                cpu_reset;
  logic                accept;
  logic                term_hit;
  logic                run_tmo;
  logic                enter_load;

  // A zero write to the monitored register is treated as "not finished yet".
  assign term_hit   = bus.mon_we && (bus.mon_addr == REG_AW'(MON_REG)) &&
                      (bus.mon_data != '0);
  // cycle_count becomes TIMEOUT on the edge that ends this run cycle.
  assign run_tmo    = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));
  assign enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    cpu_reset  = 1'b1;
    accept     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LOAD;
      ST_LOAD: begin
        load_ready = 1'b1;
        accept     = bus.load_valid;
        if (accept && (bus.load_last || (word_cnt_q == WC_W'(PROG_WORDS - 1))))
          state_d = ST_HOLD;
      end
      ST_HOLD: if (hold_cnt_q == HC_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
      ST_RUN: begin
        cpu_reset = 1'b0;
        if (term_hit || run_tmo) state_d = ST_DONE;
      end
      ST_DONE: if (bus.start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      word_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      cycle_cnt_q   <= '0;
      imem_we_p1    <= 1'b0;
      imem_addr_p1  <= '0;
      imem_wdata_p1 <= '0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      result_q      <= '0;
    end else begin
      state_q <= state_d;

      // ---- load handshake -> imem write stage (p1) ----
      imem_we_p1 <= accept;
      if (accept) begin
        imem_addr_p1  <= IADDR_W'(word_cnt_q);
        imem_wdata_p1 <= bus.load_data;
        word_cnt_q    <= word_cnt_q + 1'b1;
      end

      if (state_q == ST_HOLD) hold_cnt_q <= hold_cnt_q + 1'b1;

      if (state_q == ST_RUN) begin
        cycle_cnt_q <= sat_inc(cycle_cnt_q);
        if (term_hit) begin
          result_q <= bus.mon_data;
          pass_q   <= (bus.mon_data == DATA_W'(PASS_VALUE));
        end else if (run_tmo) begin
          timeout_q <= 1'b1;
        end
      end

      // A new start wipes the previous verdict on the same edge it is taken.
      if (enter_load) begin
        word_cnt_q  <= '0;
        hold_cnt_q  <= '0;
        cycle_cnt_q <= '0;
        pass_q      <= 1'b0;
        timeout_q   <= 1'b0;
        result_q    <= '0;
      end
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.cpu_reset   = cpu_reset;
  assign bus.imem_we     = imem_we_p1;
  assign bus.imem_addr   = imem_addr_p1;
  assign bus.imem_wdata  = imem_wdata_p1;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.pass        = pass_q;
  assign bus.timeout     = timeout_q;
  assign bus.result      = result_q;
  assign bus.cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Self-checking bench for cpu_test_sequencer: randomized program loads and
// randomized register-write traffic, checked against a transaction-level
// model of the load/hold/run/verdict rules.
module tb_cpu_test_sequencer;
  import cpu_test_sequencer_pkg::*;

  localparam int IADDR_W      = 4;
  localparam int INSTR_W      = 32;
  localparam int PROG_WORDS   = 12;
  localparam int RESET_CYCLES = 3;
  localparam int TIMEOUT      = 20;
  localparam int REG_AW       = 5;
  localparam int DATA_W       = 32;
  localparam int MON_REG      = 31;
  localparam int PASS_VALUE   = 1;
  localparam int CNT_W        = cnt_width(TIMEOUT);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cpu_test_sequencer_if #(
    .IADDR_W(IADDR_W), .INSTR_W(INSTR_W), .REG_AW(REG_AW),
    .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) bus ();

  cpu_test_sequencer #(
    .IADDR_W(IADDR_W), .INSTR_W(INSTR_W), .PROG_WORDS(PROG_WORDS),
    .RESET_CYCLES(RESET_CYCLES), .TIMEOUT(TIMEOUT), .REG_AW(REG_AW),
    .DATA_W(DATA_W), .MON_REG(MON_REG), .PASS_VALUE(PASS_VALUE)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.load_data  = '0;
    bus.mon_we     = 1'b0;
    bus.mon_addr   = '0;
    bus.mon_data   = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_load_ready"},  bus.load_ready,  0);
    check({tag, "_imem_we"},     bus.imem_we,     0);
    check({tag, "_imem_addr"},   bus.imem_addr,   0);
    check({tag, "_imem_wdata"},  bus.imem_wdata,  0);
    check({tag, "_cpu_reset"},   bus.cpu_reset,   1);
    check({tag, "_done"},        bus.done,        0);
    check({tag, "_pass"},        bus.pass,        0);
    check({tag, "_timeout"},     bus.timeout,     0);
    check({tag, "_result"},      bus.result,      0);
    check({tag, "_cycle_count"}, bus.cycle_count, 0);
  endtask

  task automatic apply_reset(input string tag);
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals(tag);
    tick();
  endtask

  // Register-file traffic that must never end the test.
  task automatic drive_mon_noise();
    int sel;
    int a;
    sel = $urandom_range(0, 2);
    a   = $urandom_range(0, (1 << REG_AW) - 1);
    if (a == MON_REG) a = MON_REG - 1;
    bus.mon_we   = (sel != 2);
    bus.mon_addr = (sel == 0) ? REG_AW'(a) : REG_AW'(MON_REG);
    bus.mon_data = (sel == 1) ? '0 : ($urandom() | 32'h1);
  endtask

  // abort_phase: 0 = complete run, 1 = reset during load, 2 = reset in run cycle 5
  task automatic do_test(input int nwords, input bit use_last, input int term_cyc,
                         input logic [DATA_W-1:0] term_val, input int abort_phase);
    logic [INSTR_W-1:0] prog [$];
    logic [INSTR_W-1:0] prev_data;
    int acc, prev_addr, budget, end_r;
    bit prev_hs, fin, first, term_ok;

    for (int i = 0; i < nwords; i++) prog.push_back($urandom());
    term_ok = (term_val != 0) && (term_cyc >= 1) && (term_cyc <= TIMEOUT);
    end_r   = term_ok ? term_cyc : TIMEOUT;

    drive_idle();
    bus.start = 1'b1;
    @(negedge clk);
    check("pre_start_ready", bus.load_ready, 0);
    tick();

    acc = 0; prev_hs = 0; fin = 0; first = 1; budget = 0;
    prev_data = '0; prev_addr = 0;
    while (!fin) begin
      bus.start      = 1'($urandom_range(0, 1));
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.load_data  = bus.load_valid ? prog[acc] : $urandom();
      bus.load_last  = bus.load_valid ? (use_last && (acc == nwords - 1))
                                      : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("load_ready", bus.load_ready, 1);
      check("load_cpu_reset", bus.cpu_reset, 1);
      check("load_done", bus.done, 0);
      if (first) begin
        check("clr_pass", bus.pass, 0);
        check("clr_timeout", bus.timeout, 0);
        check("clr_result", bus.result, 0);
        check("clr_cycle_count", bus.cycle_count, 0);
        first = 0;
      end
      check("load_imem_we", bus.imem_we, prev_hs);
      if (prev_hs) begin
        check("load_imem_addr", bus.imem_addr, prev_addr);
        check("load_imem_wdata", bus.imem_wdata, prev_data);
      end
      prev_hs = bus.load_valid;
      if (bus.load_valid) begin
        prev_data = prog[acc];
        prev_addr = acc;
        acc++;
        fin = bus.load_last || (acc == PROG_WORDS);
      end
      tick();
      if (abort_phase == 1 && acc == 2 && prev_hs) begin
        apply_reset("rst_in_load");
        return;
      end
      budget++;
      if (budget > 500 && !fin) begin
        check("load_budget_expired", 0, 1);
        fin = 1;
      end
    end

    // Hold: core stays in reset; the final imem write lands in the first cycle.
    for (int k = 1; k <= RESET_CYCLES; k++) begin
      drive_idle();
      bus.start      = 1'($urandom_range(0, 1));
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_last  = 1'($urandom_range(0, 1));
      bus.load_data  = $urandom();
      @(negedge clk);
      check("hold_ready", bus.load_ready, 0);
      check("hold_cpu_reset", bus.cpu_reset, 1);
      check("hold_imem_we", bus.imem_we, (k == 1));
      if (k == 1) begin
        check("hold_imem_addr", bus.imem_addr, prev_addr);
        check("hold_imem_wdata", bus.imem_wdata, prev_data);
      end
      tick();
    end

    for (int r = 1; r <= end_r; r++) begin
      drive_idle();
      bus.start      = 1'($urandom_range(0, 1));
      bus.load_valid = 1'($urandom_range(0, 1));
      if (r == term_cyc) begin
        bus.mon_we   = 1'b1;
        bus.mon_addr = REG_AW'(MON_REG);
        bus.mon_data = term_val;
      end else begin
        drive_mon_noise();
      end
      @(negedge clk);
      check("run_cpu_reset", bus.cpu_reset, 0);
      check("run_ready", bus.load_ready, 0);
      check("run_done", bus.done, 0);
      check("run_cycle_count", bus.cycle_count, r - 1);
      tick();
      if (abort_phase == 2 && r == 5) begin
        apply_reset("rst_in_run");
        return;
      end
    end

    // Verdict must hold through DONE regardless of further core activity.
    for (int h = 0; h < 3; h++) begin
      drive_idle();
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.mon_we     = 1'b1;
      bus.mon_addr   = REG_AW'(MON_REG);
      bus.mon_data   = $urandom() | 32'h1;
      @(negedge clk);
      check("done", bus.done, 1);
      check("done_cpu_reset", bus.cpu_reset, 1);
      check("done_ready", bus.load_ready, 0);
      check("pass", bus.pass, term_ok && (term_val == PASS_VALUE));
      check("timeout", bus.timeout, !term_ok);
      check("result", bus.result, term_ok ? term_val : 0);
      check("cycle_count", bus.cycle_count, end_r);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] v;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("por");
    tick();

    do_test(4, 1'b1, 10, 32'd1, 0);                 // pass signature
    do_test(6, 1'b1, 7, 32'h5, 0);                  // fail signature
    do_test(3, 1'b1, 9, 32'h0, 0);                  // zero write ignored -> timeout
    do_test(PROG_WORDS, 1'b0, 0, 32'h0, 0);         // full load, no signature
    do_test(PROG_WORDS + 3, 1'b0, TIMEOUT, 32'h9, 0); // signature on timeout cycle wins
    do_test(5, 1'b1, 12, 32'd1, 1);                 // reset during load
    do_test(4, 1'b1, 12, 32'd1, 2);                 // reset during run
    do_test(4, 1'b1, 10, 32'd1, 0);                 // clean reload afterwards
    do_test(1, 1'b1, 1, 32'd7, 0);                  // minimal program, immediate finish

    for (int t = 0; t < 8; t++) begin
      case ($urandom_range(0, 2))
        0:       v = PASS_VALUE;
        1:       v = $urandom();
        default: v = '0;
      endcase
      do_test($urandom_range(1, PROG_WORDS), 1'b1, $urandom_range(1, TIMEOUT + 4), v, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
